// File: rtl/histogram_peak_locator_pkg.sv
// Shared defaults and FSM encoding for the histogram pipeline.
package histogram_peak_locator_pkg;
  localparam int X_BINS_DEF  = 240;
  localparam int Y_BINS_DEF  = 180;
  localparam int COUNT_W_DEF = 8;
  localparam int IDX_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/hist_axis_scan.sv
// One histogram axis: bin counter, running peak, occupied bounds.
// Exposes next-state values so the top can latch results on the same edge
// that accepts the last beat.
module hist_axis_scan
  import histogram_peak_locator_pkg::*;
#(
  parameter int BINS    = X_BINS_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               active_i,
  input  logic               valid_i,
  input  logic [COUNT_W-1:0] count_i,
  input  logic [COUNT_W-1:0] thr_i,
  output logic [IDX_W-1:0]   peak_idx_d_o,
  output logic [COUNT_W-1:0] peak_cnt_d_o,
  output logic [IDX_W-1:0]   min_d_o,
  output logic [IDX_W-1:0]   max_d_o,
  output logic               occ_d_o,
  output logic               done_d_o,
  output logic               ovr_o
);
  // One extra bit so the counter can hold BINS even when BINS == 2^IDX_W.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] BINS_C = CNT_W'(BINS);

  logic [CNT_W-1:0]   cnt_q, cnt_b, cnt_d;
  logic [COUNT_W-1:0] pk_cnt_q, pk_cnt_b, pk_cnt_d;
  logic [IDX_W-1:0]   pk_idx_q, pk_idx_b, pk_idx_d;
  logic [IDX_W-1:0]   min_q, min_b, min_d;
  logic [IDX_W-1:0]   max_q, max_b, max_d;
  logic               occ_q, occ_b, occ_d;
  logic [IDX_W-1:0]   idx;

  // Next state: start from cleared values on frameStart so a coincident beat is bin 0.
  always_comb begin
    cnt_b    = clear_i ? '0 : cnt_q;
    pk_cnt_b = clear_i ? '0 : pk_cnt_q;
    pk_idx_b = clear_i ? '0 : pk_idx_q;
    min_b    = clear_i ? '1 : min_q;
    max_b    = clear_i ? '0 : max_q;
    occ_b    = clear_i ? 1'b0 : occ_q;
    cnt_d    = cnt_b;
    pk_cnt_d = pk_cnt_b;
    pk_idx_d = pk_idx_b;
    min_d    = min_b;
    max_d    = max_b;
    occ_d    = occ_b;
    ovr_o    = 1'b0;
    idx      = cnt_b[IDX_W-1:0];
    if (valid_i && (active_i || clear_i)) begin
      if (cnt_b == BINS_C) begin
        ovr_o = 1'b1;
      end else begin
        // Strict compare keeps the lower index on ties.
        if (count_i > pk_cnt_b) begin
          pk_cnt_d = count_i;
          pk_idx_d = idx;
        end
        if (count_i > thr_i) begin
          if (!occ_b) min_d = idx;
          max_d = idx;
          occ_d = 1'b1;
        end
        cnt_d = cnt_b + 1'b1;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      pk_cnt_q <= '0;
      pk_idx_q <= '0;
      min_q    <= '1;
      max_q    <= '0;
      occ_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pk_cnt_q <= pk_cnt_d;
      pk_idx_q <= pk_idx_d;
      min_q    <= min_d;
      max_q    <= max_d;
      occ_q    <= occ_d;
    end
  end

  assign peak_idx_d_o = pk_idx_d;
  assign peak_cnt_d_o = pk_cnt_d;
  assign min_d_o      = min_d;
  assign max_d_o      = max_d;
  assign occ_d_o      = occ_d;
  assign done_d_o     = (cnt_d == BINS_C);
endmodule

// File: rtl/histogram_peak_locator.sv
// Per-frame peak / bounding-box locator over x and y histogram streams.
module histogram_peak_locator
  import histogram_peak_locator_pkg::*;
#(
  parameter int X_BINS  = X_BINS_DEF,
  parameter int Y_BINS  = Y_BINS_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frameStart,
  input  logic [COUNT_W-1:0] binThreshold,
  input  logic [COUNT_W-1:0] xHistogramIn,
  input  logic               xValid,
  input  logic [COUNT_W-1:0] yHistogramIn,
  input  logic               yValid,
  output logic [IDX_W-1:0]   xPeakIdx,
  output logic [COUNT_W-1:0] xPeakCount,
  output logic [IDX_W-1:0]   yPeakIdx,
  output logic [COUNT_W-1:0] yPeakCount,
  output logic [IDX_W-1:0]   xMin,
  output logic [IDX_W-1:0]   xMax,
  output logic [IDX_W-1:0]   yMin,
  output logic [IDX_W-1:0]   yMax,
  output logic               objectFound,
  output logic               resultValid,
  output logic               busy,
  output logic               overrun
);
  state_e state_q;
  logic   active;

  logic [IDX_W-1:0]   x_pi, y_pi, x_mn, x_mx, y_mn, y_mx;
  logic [COUNT_W-1:0] x_pc, y_pc;
  logic               x_occ, y_occ, x_done, y_done, x_ovr, y_ovr;

  logic [IDX_W-1:0]   x_pi_q, y_pi_q, x_mn_q, x_mx_q, y_mn_q, y_mx_q;
  logic [COUNT_W-1:0] x_pc_q, y_pc_q;
  logic               found_q, rv_q, busy_q, ovr_q;

  assign active = (state_q != ST_IDLE);

  hist_axis_scan #(.BINS(X_BINS), .COUNT_W(COUNT_W), .IDX_W(IDX_W)) u_x (
    .clk(clk), .reset(reset), .clear_i(frameStart), .active_i(active),
    .valid_i(xValid), .count_i(xHistogramIn), .thr_i(binThreshold),
    .peak_idx_d_o(x_pi), .peak_cnt_d_o(x_pc), .min_d_o(x_mn), .max_d_o(x_mx),
    .occ_d_o(x_occ), .done_d_o(x_done), .ovr_o(x_ovr)
  );

  hist_axis_scan #(.BINS(Y_BINS), .COUNT_W(COUNT_W), .IDX_W(IDX_W)) u_y (
    .clk(clk), .reset(reset), .clear_i(frameStart), .active_i(active),
    .valid_i(yValid), .count_i(yHistogramIn), .thr_i(binThreshold),
    .peak_idx_d_o(y_pi), .peak_cnt_d_o(y_pc), .min_d_o(y_mn), .max_d_o(y_mx),
    .occ_d_o(y_occ), .done_d_o(y_done), .ovr_o(y_ovr)
  );

  // Frame FSM with registered results; results latch on the edge that
  // completes both axes so resultValid lands one cycle after the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_pi_q  <= '0; x_pc_q <= '0; x_mn_q <= '0; x_mx_q <= '0;
      y_pi_q  <= '0; y_pc_q <= '0; y_mn_q <= '0; y_mx_q <= '0;
      found_q <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (frameStart) begin
        state_q <= ST_COLLECT;
        busy_q  <= 1'b1;
        ovr_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_COLLECT: begin
            ovr_q <= ovr_q | x_ovr | y_ovr;
            if (x_done && y_done) begin
              state_q <= ST_DONE;
              rv_q    <= 1'b1;
              x_pi_q  <= x_pi;
              x_pc_q  <= x_pc;
              y_pi_q  <= y_pi;
              y_pc_q  <= y_pc;
              x_mn_q  <= x_occ ? x_mn : '0;
              x_mx_q  <= x_occ ? x_mx : '0;
              y_mn_q  <= y_occ ? y_mn : '0;
              y_mx_q  <= y_occ ? y_mx : '0;
              found_q <= x_occ & y_occ;
            end
          end
          ST_DONE: begin
            ovr_q   <= ovr_q | x_ovr | y_ovr;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign xPeakIdx    = x_pi_q;
  assign xPeakCount  = x_pc_q;
  assign yPeakIdx    = y_pi_q;
  assign yPeakCount  = y_pc_q;
  assign xMin        = x_mn_q;
  assign xMax        = x_mx_q;
  assign yMin        = y_mn_q;
  assign yMax        = y_mx_q;
  assign objectFound = found_q;
  assign resultValid = rv_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;
endmodule

// File: doc/histogram_peak_locator.md
Name: histogram_peak_locator

Overview:
- Sits directly downstream of the histogram stage and consumes its xHistogramOut/xValid and yHistogramOut/yValid bin streams.
- Per frame, finds for each axis the peak bin index and count, plus the first and last bin whose count exceeds a bin threshold.
- Presents an object bounding box and peak coordinate to the tracking/readout logic, with a single-cycle resultValid pulse.

Parameters:
X_BINS, 240, number of x-histogram bins per frame (image width)
Y_BINS, 180, number of y-histogram bins per frame (image height)
COUNT_W, 8, width of one histogram bin count
IDX_W, 8, width of a bin index; must satisfy 2^IDX_W >= max(X_BINS, Y_BINS)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frameStart  input  1  one-cycle pulse that clears accumulators and arms a new frame
binThreshold  input  COUNT_W  bin counts strictly greater than this are "occupied"
xHistogramIn  input  COUNT_W  x bin count; bin index is implied by arrival order
xValid  input  1  xHistogramIn is valid this cycle
yHistogramIn  input  COUNT_W  y bin count; bin index is implied by arrival order
yValid  input  1  yHistogramIn is valid this cycle
xPeakIdx  output  IDX_W  index of the largest x bin
xPeakCount  output  COUNT_W  count of the largest x bin
yPeakIdx  output  IDX_W  index of the largest y bin
yPeakCount  output  COUNT_W  count of the largest y bin
xMin, xMax  output  IDX_W each  first and last occupied x bin
yMin, yMax  output  IDX_W each  first and last occupied y bin
objectFound  output  1  at least one occupied bin on both axes
resultValid  output  1  one-cycle pulse when results update
busy  output  1  a frame is being collected
overrun  output  1  sticky: extra beats received after an axis completed; cleared by frameStart

Behaviour:
- Reset (async): FSM=IDLE. All outputs are 0. Internal bin counters are 0 and min registers hold all-ones.
- FSM states and transitions:
  - IDLE: frameStart -> COLLECT.
  - COLLECT: leaves when both axes are complete (xCnt==X_BINS and yCnt==Y_BINS) -> DONE.
  - DONE: one cycle. Result registers are loaded and resultValid=1 -> IDLE.
  - frameStart in any state: clears all accumulators and overrun and forces COLLECT. The previous result outputs hold until the next DONE.
- busy=1 in COLLECT and DONE.
- Valid beats are ignored in IDLE.
- Axes are independent: xValid and yValid may be concurrent, interleaved or sequential. Each axis has its own bin counter.
- Each valid beat in COLLECT, with idx = current axis counter:
  - If count > running max: max <= count and peakIdx <= idx. Ties keep the lower index. With an all-zero histogram, peakIdx=0 and peakCount=0.
  - If count > binThreshold: if no bin is occupied yet, min <= idx; in all cases max-bound <= idx.
  - Counter increments.
- Beats arriving when an axis counter already equals its BINS value are discarded and set overrun.
- objectFound = (x occupied) AND (y occupied).
- If an axis has no occupied bin, its Min and Max outputs are 0.
- Latency: resultValid asserts exactly 1 cycle after the cycle that accepts the last required beat. Outputs are registered and change only in DONE.
- frameStart together with a valid beat in the same cycle: the beat is treated as bin 0 of the new frame.
- Comparisons are unsigned. No arithmetic widening is needed.

Decomposition:
- Shared package holds the X_BINS/Y_BINS/COUNT_W/IDX_W defaults and the FSM state encoding (IDLE, COLLECT, DONE). The histogram stage uses the same package.
- One sub-module, hist_axis_scan, is instantiated twice (x and y). It contains:
  - the counter, running max/peakIdx, occupied flag and min/max bounds;
  - a done flag and an overrun pulse.
- The top level holds the FSM, result registers and sticky overrun.

Test Plan:
- Reset mid-COLLECT: all outputs go to 0 immediately (async), busy=0, and no resultValid follows.
- Single spot: x bins 100..104 and y bins 50..52 = 40, all others 0, binThreshold=10 -> xPeakIdx=100, xPeakCount=40, xMin=100, xMax=104, yPeakIdx=50, yMin=50, yMax=52, objectFound=1, one resultValid pulse.
- Tie and full-scale: x bins 10 and 200 = 255, binThreshold=254 -> xPeakIdx=10, xMin=10, xMax=200.
- Empty frame: all bins = 5, binThreshold=10 -> objectFound=0, xMin=xMax=yMin=yMax=0, xPeakIdx=0, xPeakCount=5.
- Interleaving: y stream is sent fully, then x with gaps in xValid -> resultValid occurs exactly 1 cycle after x beat 239. A 241st x beat sets overrun=1; a following frameStart clears it.
- Back-to-back frames: frameStart is asserted during COLLECT of frame 1 -> frame-1 results are not reported, and frame-2 results are correct.
